// File: rtl/seg_op_arbiter_if.sv
// Purpose: bundles the two requester channels and the display/result side of seg_op_arbiter.
// Latency: none (wires only).
// Backpressure: none; requests are level signals, and each accepted request gets a one-cycle ack.
// Ports: req*/in0_*/in1_*/op_code* come from the requesters; ack0/ack1/busy/grant_id/result/seg go back to them.
interface seg_op_arbiter_if #(
    parameter int N = 4
);
    logic         req0;
    logic [N-1:0] in0_0;
    logic [N-1:0] in1_0;
    logic [1:0]   op_code0;
    logic         req1;
    logic [N-1:0] in0_1;
    logic [N-1:0] in1_1;
    logic [1:0]   op_code1;
    logic         ack0;
    logic         ack1;
    logic         busy;
    logic         grant_id;
    logic [N-1:0] result;
    logic [6:0]   seg;

    // The requester side drives the requests and watches the acks and the display.
    modport master (
        output req0, in0_0, in1_0, op_code0,
        output req1, in0_1, in1_1, op_code1,
        input  ack0, ack1, busy, grant_id, result, seg
    );

    // The arbiter side takes the requests and drives the acks and the display.
    modport slave (
        input  req0, in0_0, in1_0, op_code0,
        input  req1, in0_1, in1_1, op_code1,
        output ack0, ack1, busy, grant_id, result, seg
    );
endinterface

// File: rtl/seg_op_arbiter.sv
// Purpose: round-robin arbiter for two requesters; computes a 2-bit ALU op and shows the result as a 7-segment glyph.
// Latency: grant edge -> ack/result/seg one edge later; the display is then held for HOLD cycles (service every HOLD+2 cycles).
// Backpressure: requests are sampled only in IDLE; while busy, requests and operands are ignored.
// Ports: clk, rst (async active-high), bus (seg_op_arbiter_if.slave: requests in; ack0/ack1, busy, grant_id, result, seg out).
module seg_op_arbiter #(
    parameter int N    = 4,   // operand/result width; must be at least 4 for the glyph lookup
    parameter int HOLD = 8    // display hold in cycles, 1..65535
) (
    input  logic            clk,
    input  logic            rst,
    seg_op_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHOW} state_t;

    localparam logic [15:0] HOLD_CNT = 16'(HOLD);

    state_t       state;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [1:0]   op_q;
    logic         gid_q;      // requester captured at the grant
    logic         last_q;     // requester granted most recently
    logic [15:0]  cnt;
    logic [N-1:0] result_q;
    logic [6:0]   seg_q;
    logic         ack0_q;
    logic         ack1_q;
    logic         busy_q;
    logic         grant_id_q;

    logic [N-1:0] alu;
    logic         win;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1111110;
            4'h1: glyph = 7'b0110000;
            4'h2: glyph = 7'b1101101;
            4'h3: glyph = 7'b1111001;
            4'h4: glyph = 7'b0110011;
            4'h5: glyph = 7'b1011011;
            4'h6: glyph = 7'b1011111;
            4'h7: glyph = 7'b1110000;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1111011;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b0011111;
            4'hC: glyph = 7'b1001110;
            4'hD: glyph = 7'b0111101;
            4'hE: glyph = 7'b1001111;
            default: glyph = 7'b1000111;
        endcase
    endfunction

    // Carry and borrow fall off the top naturally, giving results modulo 2^N.
    always_comb begin
        alu = '0;
        case (op_q)
            2'b00: alu = a_q + b_q;
            2'b01: alu = a_q | b_q;
            2'b10: alu = a_q - b_q;
            default: alu = a_q ^ b_q;
        endcase
    end

    // On a tie, the requester not granted last wins. last_q resets to 1, so requester 0 wins the first tie.
    always_comb begin
        win = 1'b0;
        if (bus.req0 && bus.req1) win = ~last_q;
        else                      win = bus.req1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 2'b00;
            gid_q      <= 1'b0;
            last_q     <= 1'b1;
            cnt        <= 16'd0;
            result_q   <= '0;
            seg_q      <= 7'b0000000;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            grant_id_q <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        gid_q  <= win;
                        last_q <= win;
                        a_q    <= win ? bus.in0_1    : bus.in0_0;
                        b_q    <= win ? bus.in1_1    : bus.in1_0;
                        op_q   <= win ? bus.op_code1 : bus.op_code0;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    result_q   <= alu;
                    seg_q      <= glyph(alu[3:0]);
                    ack0_q     <= ~gid_q;
                    ack1_q     <= gid_q;
                    grant_id_q <= gid_q;
                    cnt        <= HOLD_CNT;
                    state      <= SHOW;
                end
                SHOW: begin
                    // Values HOLD down to 1 each take one SHOW cycle; the cycle at 1 is the last one.
                    if (cnt <= 16'd1) begin
                        cnt    <= 16'd0;
                        seg_q  <= 7'b0000000;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_id_q;
    assign bus.result   = result_q;
    assign bus.seg      = seg_q;
endmodule

// File: tb/tb_seg_op_arbiter.sv
// Purpose: directed self-checking bench for seg_op_arbiter (HOLD=4/N=4 instance and HOLD=1/N=8 instance).
// Latency: expected values hand-computed; outputs sampled on the falling edge.
// Backpressure: every wait on the DUT is bounded; a timeout counts as a failed check.
module tb_seg_op_arbiter;
    logic clk = 1'b0;
    logic rst4;
    logic rst1;
    always #5 clk = ~clk;

    seg_op_arbiter_if #(.N(4)) b4 ();
    seg_op_arbiter_if #(.N(8)) b1 ();

    seg_op_arbiter #(.N(4), .HOLD(4)) dut4 (.clk(clk), .rst(rst4), .bus(b4));
    seg_op_arbiter #(.N(8), .HOLD(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1));

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G6 = 7'b1011111;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G9 = 7'b1111011;
    localparam logic [6:0] GD = 7'b0111101;
    localparam logic [6:0] GF = 7'b1000111;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack4(input string tag, output int ack_at, output logic id);
        ack_at = 0;
        id     = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b4.ack0 || b4.ack1) begin
                ack_at = cyc;
                id     = b4.ack1;
                return;
            end
        end
        check({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle4(input string tag);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!b4.busy) return;
        end
        check({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] op, input logic [3:0] exp_res, input logic [6:0] exp_seg);
        int   at;
        logic id;
        b4.req0 = 1'b1; b4.in0_0 = a; b4.in1_0 = b; b4.op_code0 = op;
        wait_ack4(tag, at, id);
        b4.req0 = 1'b0;
        check({tag, "_id"},  32'(id), 32'd0);
        check({tag, "_res"}, 32'(b4.result), 32'(exp_res));
        check({tag, "_seg"}, 32'(b4.seg), 32'(exp_seg));
        wait_idle4(tag);
        check({tag, "_blank"}, 32'(b4.seg), 32'd0);
    endtask

    initial begin
        int   at;
        int   prev;
        logic id;
        int   acks;
        bit   got;

        rst4 = 1'b1; rst1 = 1'b1;
        b4.req0 = 0; b4.in0_0 = 0; b4.in1_0 = 0; b4.op_code0 = 0;
        b4.req1 = 0; b4.in0_1 = 0; b4.in1_1 = 0; b4.op_code1 = 0;
        b1.req0 = 0; b1.in0_0 = 0; b1.in1_0 = 0; b1.op_code0 = 0;
        b1.req1 = 0; b1.in0_1 = 0; b1.in1_1 = 0; b1.op_code1 = 0;

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_busy", 32'(b4.busy), 32'd0);
        check("rst_seg",  32'(b4.seg), 32'd0);
        check("rst_res",  32'(b4.result), 32'd0);
        check("rst_ack",  32'({b4.ack1, b4.ack0}), 32'd0);
        check("rst_gid",  32'(b4.grant_id), 32'd0);
        check("rst1_seg", 32'(b1.seg), 32'd0);

        // Basic add 3+4, with exact display timing
        rst4 = 1'b0;
        b4.req0 = 1'b1; b4.in0_0 = 4'd3; b4.in1_0 = 4'd4; b4.op_code0 = 2'b00;
        @(negedge clk);
        check("load_busy", 32'(b4.busy), 32'd1);
        check("load_ack",  32'(b4.ack0), 32'd0);
        check("load_seg",  32'(b4.seg), 32'd0);
        @(negedge clk);
        b4.req0 = 1'b0;
        check("add_ack", 32'(b4.ack0), 32'd1);
        check("add_res", 32'(b4.result), 32'd7);
        check("add_seg", 32'(b4.seg), 32'(G7));
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("show%0d_ack", k), 32'(b4.ack0), 32'd0);
            check($sformatf("show%0d_seg", k), 32'(b4.seg), 32'(G7));
        end
        @(negedge clk);
        check("end_seg",  32'(b4.seg), 32'd0);
        check("end_busy", 32'(b4.busy), 32'd0);

        // Opcode decode and wraparound
        op4("sub_wrap", 4'd2, 4'd5, 2'b10, 4'hD, GD);
        op4("xor",      4'hA, 4'h5, 2'b11, 4'hF, GF);
        op4("or",       4'h8, 4'h1, 2'b01, 4'h9, G9);
        op4("add_wrap", 4'hF, 4'h3, 2'b00, 4'h2, G2);

        // Both requesters held from reset: grants alternate, spaced HOLD+2
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        b4.req0 = 1'b1; b4.in0_0 = 4'd1; b4.in1_0 = 4'd1; b4.op_code0 = 2'b00;
        b4.req1 = 1'b1; b4.in0_1 = 4'd5; b4.in1_1 = 4'd3; b4.op_code1 = 2'b11;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack4($sformatf("rr%0d", k), at, id);
            check($sformatf("rr%0d_id", k),  32'(id), 32'(k % 2));
            check($sformatf("rr%0d_gid", k), 32'(b4.grant_id), 32'(k % 2));
            check($sformatf("rr%0d_res", k), 32'(b4.result), (k % 2) ? 32'd6 : 32'd2);
            if (k > 0) check($sformatf("rr%0d_gap", k), 32'(at - prev), 32'd6);
            prev = at;
        end
        b4.req0 = 1'b0; b4.req1 = 1'b0;
        wait_idle4("rr");

        // Requester 1 arrives during requester 0's SHOW; operands change mid-SHOW
        b4.req0 = 1'b1; b4.in0_0 = 4'd3; b4.in1_0 = 4'd4; b4.op_code0 = 2'b00;
        wait_ack4("late0", at, id);
        check("late0_id", 32'(id), 32'd0);
        b4.req0 = 1'b0;
        b4.req1 = 1'b1; b4.in0_1 = 4'd2; b4.in1_1 = 4'd1; b4.op_code1 = 2'b00;
        prev = at;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                b4.in1_1 = 4'd6;
                b4.in0_0 = 4'd9;
            end
            check($sformatf("late0_seg%0d", k), 32'(b4.seg), 32'(G7));
            check($sformatf("late0_res%0d", k), 32'(b4.result), 32'd7);
        end
        wait_ack4("late1", at, id);
        b4.req1 = 1'b0;
        check("late1_id",  32'(id), 32'd1);
        check("late1_res", 32'(b4.result), 32'd8);
        check("late1_seg", 32'(b4.seg), 32'(G8));
        check("late1_gap", 32'(at - prev), 32'd6);
        wait_idle4("late1");

        // Reset during SHOW cycle 2 aborts at once
        b4.req0 = 1'b1; b4.in0_0 = 4'd1; b4.in1_0 = 4'd2; b4.op_code0 = 2'b00;
        wait_ack4("abort", at, id);
        check("abort_pre_seg", 32'(b4.seg), 32'(G3));
        b4.req0 = 1'b0;
        @(negedge clk);
        #1 rst4 = 1'b1;
        #1;
        check("abort_seg",  32'(b4.seg), 32'd0);
        check("abort_busy", 32'(b4.busy), 32'd0);
        check("abort_res",  32'(b4.result), 32'd0);
        @(negedge clk);
        rst4 = 1'b0;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b4.ack0 || b4.ack1) acks++;
        end
        check("abort_noack", 32'(acks), 32'd0);
        check("abort_idle",  32'(b4.busy), 32'd0);
        // Pointer reset: a tie after reset goes to requester 0
        b4.req0 = 1'b1; b4.in0_0 = 4'd2; b4.in1_0 = 4'd2; b4.op_code0 = 2'b00;
        b4.req1 = 1'b1; b4.in0_1 = 4'd0; b4.in1_1 = 4'd0; b4.op_code1 = 2'b00;
        wait_ack4("post_rst", at, id);
        b4.req0 = 1'b0; b4.req1 = 1'b0;
        check("post_rst_id",  32'(id), 32'd0);
        check("post_rst_res", 32'(b4.result), 32'd4);
        wait_idle4("post_rst");

        // HOLD=1, N=8: acks every 3 cycles, glyph from the low nibble only
        @(negedge clk);
        rst1 = 1'b0;
        b1.req0 = 1'b1; b1.in0_0 = 8'h25; b1.in1_0 = 8'h13; b1.op_code0 = 2'b00;
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (b1.ack0) got = 1'b1;
            end
            check($sformatf("h1_ack%0d", k), 32'(got), 32'd1);
            check($sformatf("h1_res%0d", k), 32'(b1.result), 32'h38);
            check($sformatf("h1_seg%0d", k), 32'(b1.seg), 32'(G8));
            if (k > 0) check($sformatf("h1_gap%0d", k), 32'(cyc - prev), 32'd3);
            prev = cyc;
            @(negedge clk);
            check($sformatf("h1_blank%0d", k), 32'(b1.seg), 32'd0);
            check($sformatf("h1_idle%0d", k),  32'(b1.busy), 32'd0);
        end
        b1.req0 = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        b1.req0 = 1'b1; b1.in0_0 = 8'h10; b1.in1_0 = 8'h20; b1.op_code0 = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b1.ack0) got = 1'b1;
        end
        b1.req0 = 1'b0;
        check("h1_wide_ack", 32'(got), 32'd1);
        check("h1_wide_res", 32'(b1.result), 32'hF0);
        check("h1_wide_seg", 32'(b1.seg), 32'(G0));
        b1.req1 = 1'b1; b1.in0_1 = 8'hA3; b1.in1_1 = 8'h05; b1.op_code1 = 2'b11;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (b1.ack1) got = 1'b1;
        end
        b1.req1 = 1'b0;
        check("h1_r1_ack", 32'(got), 32'd1);
        check("h1_r1_res", 32'(b1.result), 32'hA6);
        check("h1_r1_seg", 32'(b1.seg), 32'(G6));
        check("h1_r1_gid", 32'(b1.grant_id), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg_op_arbiter.md
SEG_OP_ARBITER -- requirements
Module: seg_op_arbiter

Interface
REQ-001 Parameter N, default 4, operand/result width in bits.
REQ-002 Parameter HOLD, default 8, display hold time in clock cycles; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  requester 0 operation request, level.
REQ-006 in0_0  input  N  requester 0 first operand.
REQ-007 in1_0  input  N  requester 0 second operand.
REQ-008 op_code0  input  2  requester 0 operation.
REQ-009 req1, in0_1, in1_1, op_code1  input  1/N/N/2  requester 1 equivalents of REQ-005..008.
REQ-010 ack0, ack1  output  1 each  one-cycle grant acknowledge to requester 0/1.
REQ-011 busy  output  1  high while an operation is latched or displayed.
REQ-012 grant_id  output  1  index of requester whose result is displayed; valid while busy.
REQ-013 result  output  N  registered operation result; valid while busy.
REQ-014 seg  output  7  segment drive {a,b,c,d,e,f,g}, active-high.

Function
REQ-015 The block SHALL implement FSM states IDLE, LOAD and SHOW.
REQ-016 Operation decode SHALL be: 00 = in0+in1, 01 = in0|in1, 10 = in0-in1, 11 = in0^in1; all results modulo 2^N, carry/borrow discarded.
REQ-017 In IDLE with no request asserted, the FSM SHALL stay in IDLE; busy=0, seg=7'b0000000 (blank).
REQ-018 In IDLE with at least one request asserted, the FSM SHALL grant one requester, capture its operands and op_code on that edge, and move to LOAD.
REQ-019 Arbitration SHALL be round-robin: if only one request is high it wins; if both are high, the requester not granted last wins; after reset, requester 0 wins a tie.
REQ-020 In LOAD, the FSM SHALL compute the result from the captured values, register it into result, register the glyph into seg, pulse the granted ack for exactly this one cycle, set grant_id, and move to SHOW.
REQ-021 In SHOW, the FSM SHALL hold result and seg for exactly HOLD cycles, counted by an internal 16-bit down-counter, then return to IDLE.
REQ-022 Requests arriving or changing during LOAD or SHOW SHALL be ignored. They are sampled again only in IDLE.
REQ-023 Operand changes after capture SHALL NOT affect result or seg.
REQ-024 A requester holding req high after its ack SHALL be served again. Round-robin SHALL still give the other requester priority when both are pending.
REQ-025 busy SHALL be 1 in LOAD and SHOW, and 0 in IDLE.
REQ-026 The glyph table for values 0..F SHALL be: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
REQ-027 For N>4, only result[3:0] SHALL drive the glyph lookup.
REQ-028 Minimum request-to-request service spacing SHALL be HOLD+2 cycles: 1 cycle IDLE grant, 1 cycle LOAD, HOLD cycles SHOW.

Reset
REQ-029 While rst is high, the block SHALL force state=IDLE, result=0, seg=0000000, ack0=ack1=0, busy=0, grant_id=0, hold counter=0, and round-robin pointer to favour requester 0.
REQ-030 Reset asserted in LOAD or SHOW SHALL abort the operation immediately (asynchronously). No ack SHALL be issued for an aborted operation that has not reached LOAD.
REQ-031 After reset deasserts, the first rising edge SHALL evaluate requests as in IDLE.

Verification
REQ-032 HOLD=4; req0=1, in0_0=3, in1_0=4, op_code0=00 -> ack0 pulses 1 cycle after grant, result=7, seg=1110000 for 4 cycles, then seg=0000000.
REQ-033 op_code0=10, in0_0=2, in1_0=5 -> result=4'hD (wrap), seg=0111101; op 11 with 4'hA^4'h5 -> result=F, seg=1000111.
REQ-034 req0 and req1 both held high from reset -> grants alternate 0,1,0,1; each ack separated by HOLD+2 cycles.
REQ-035 req1 asserted alone during requester 0's SHOW, in1_1 changed mid-SHOW -> requester 0 display undisturbed; requester 1 served on the next IDLE with operands sampled at that grant.
REQ-036 rst pulsed during SHOW cycle 2 -> seg=0000000, busy=0 immediately; no further ack until a new request is granted.
REQ-037 HOLD=1 -> SHOW lasts exactly 1 cycle; back-to-back requests are acked every 3 cycles.
